muldiv_seq: RTL
===============

# muldiv_seq

Parametrised iterative multiply/divide unit with HI/LO result registers.
- Executes MULT, MULTU, DIV and DIVU over WIDTH-bit operands.
- Sits beside the single-cycle ALU, driven by the same decode path that produces the Mul/Div/Mfhi ALU operations.
- HI/LO are held here and read continuously, so an Mfhi-class path needs no extra state.
- A start/busy/done handshake lets the control unit stall the pipeline while an operation runs.

## Interface
- WIDTH, 32, operand and HI/LO width (≥ 4).
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; accepted only when busy=0.
- flush  in  1  synchronous abort of an operation in progress.
- op  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- a  in  WIDTH  rs operand, multiplicand or dividend.
- b  in  WIDTH  rt operand, multiplier or divisor.
- busy  out  1  operation in progress; the control unit stalls on it.
- done  out  1  one-cycle pulse; HI/LO valid in that same cycle.
- hi  out  WIDTH  product upper half, or division remainder.
- lo  out  WIDTH  product lower half, or division quotient.
- div_by_zero  out  1  sticky until next accepted start; set by DIV/DIVU with b=0.

## Operation
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1: latch op, sign flags (signed ops only) and operand magnitudes.
  - Clear the iteration counter and div_by_zero.
  - Go to RUN.
  - Exception: DIV/DIVU with b=0 goes straight to FIX.
- RUN: one radix-2 step per cycle, exactly WIDTH cycles, then FIX.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract on the magnitudes.
- FIX: apply sign correction, write hi/lo, assert done in the next cycle, go to IDLE.
- Signed multiply: product negated when sign(a)≠sign(b); full 2·WIDTH result goes to {hi,lo}.
- Signed divide:
  - Quotient negated when sign(a)≠sign(b).
  - Remainder takes the sign of a.
  - Most-negative ÷ −1 gives lo = most-negative, hi = 0. This wraps naturally; no trap.
- Divide by zero:
  - hi = a, lo = all ones, div_by_zero = 1.
  - No iterations are run.
- hi/lo change only in FIX. They hold their value otherwise, including across flush.
- start while busy=1: ignored. No queueing, no error.
- flush:
  - In RUN or FIX: return to IDLE next cycle.
  - hi/lo and div_by_zero unchanged; no done.
  - flush and start together in IDLE: flush wins, start dropped.
- Asynchronous reset mid-operation: immediate return to IDLE with all outputs at their reset values.
- Unsigned ops treat operands as plain magnitudes.

## Timing
- Reset values: hi=0, lo=0, busy=0, done=0, div_by_zero=0, state IDLE.
- Numbering: start sampled on edge 0.
- Normal operation:
  - busy=1 in cycles 1..WIDTH+1: WIDTH RUN cycles plus 1 FIX cycle.
  - done=1 and busy=0 in cycle WIDTH+2, with the new hi/lo visible.
  - Latency is WIDTH+2 cycles (34 for WIDTH=32).
- Divide by zero:
  - busy=1 in cycle 1 (FIX).
  - done in cycle 2.
- Back-to-back: a start in the done cycle is accepted; throughput is one operation per WIDTH+2 cycles.
- done is never asserted while busy=1.
- No combinational path from inputs to outputs.

## Structure
- Shared package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU;
  - the state enum;
  - the mapping from the existing Funct-field encodings for Mul/Div to op.
- muldiv_seq holds the FSM, counter (clog2(WIDTH+1) bits), operand latches and hi/lo.
- One combinational sub-module, muldiv_step, performs a single iteration:
  - inputs: mode, accumulator, operand;
  - outputs: next accumulator and quotient bit.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done in cycle 34, hi=0xFFFFFFFE, lo=0x00000001, busy high in cycles 1–33.
- MULT a=0xFFFFFFFD (−3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULT 0x80000000×0x80000000 → hi=0x40000000, lo=0.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=7, b=2 → lo=3, hi=1.
- DIV 0x80000000÷0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=5, b=0 → done in cycle 2, div_by_zero=1, hi=5, lo=0xFFFFFFFF.
  - Next accepted start clears div_by_zero.
- Control cases:
  - start held high through a whole operation → exactly one done.
  - flush in cycle 10 → no done, hi/lo unchanged.
  - rst_n low in cycle 5 → all outputs 0 immediately.
  - start in the done cycle → second result at cycle 68.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM states and the decode mapping from the R-type Funct field.
package muldiv_pkg;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FIX
    } md_state_t;

    function automatic logic [1:0] funct_to_op(input logic [5:0] funct);
        case (funct)
            FUNCT_MULT:  return MD_MULT;
            FUNCT_MULTU: return MD_MULTU;
            FUNCT_DIV:   return MD_DIV;
            FUNCT_DIVU:  return MD_DIVU;
            default:     return MD_MULT;
        endcase
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring shift-subtract
// for divide. The quotient bit is reported separately; the LSB of next_acc is 0 in divide mode.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               div_mode,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    output logic [2*WIDTH-1:0] next_acc,
    output logic               q_bit
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_shift;
    logic [WIDTH:0] diff;

    // Divide: acc = {partial remainder, remaining dividend bits}; a clear top
    // bit of diff means the shifted remainder covered the divisor.
    always_comb begin
        sum       = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, operand};
        rem_shift = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_shift - {1'b0, operand};
        next_acc  = '0;
        q_bit     = 1'b0;
        if (div_mode) begin
            if (!diff[WIDTH]) begin
                next_acc = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
                q_bit    = 1'b1;
            end else begin
                next_acc = {rem_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else if (acc[0]) begin
            next_acc = {sum, acc[WIDTH-1:1]};
        end else begin
            next_acc = {1'b0, acc[2*WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_seq.sv
// Iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers, with a
// start/busy/done handshake so the control unit can stall while it runs.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flush,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    md_state_t          state, next_state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] step_acc;
    logic [2*WIDTH-1:0] fix_prod;
    logic [WIDTH-1:0]   opnd;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;
    logic               op_div;
    logic               neg_q;
    logic               neg_r;
    logic               zero_div;
    logic               q_bit;
    logic               in_div;
    logic               in_signed;
    logic               a_neg;
    logic               b_neg;
    logic               b_zero;
    logic               accept;

    assign in_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign in_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = in_signed && a[WIDTH-1];
    assign b_neg     = in_signed && b[WIDTH-1];
    assign mag_a     = a_neg ? -a : a;
    assign mag_b     = b_neg ? -b : b;
    assign b_zero    = (b == '0);
    assign accept    = (state == ST_IDLE) && start && !flush;
    assign busy      = (state != ST_IDLE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div_mode (op_div),
        .acc      (acc),
        .operand  (opnd),
        .next_acc (step_acc),
        .q_bit    (q_bit)
    );

    always_comb begin
        fix_prod = neg_q ? -acc : acc;
        fix_lo   = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        fix_hi   = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (accept) next_state = (in_div && b_zero) ? ST_FIX : ST_RUN;
            end
            ST_RUN: begin
                if (flush)                             next_state = ST_IDLE;
                else if (cnt == CNT_W'(WIDTH - 1))     next_state = ST_FIX;
            end
            ST_FIX:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    // On a divide by zero the operand register keeps the raw dividend,
    // since no iterations run and FIX returns it unchanged in hi.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            acc         <= '0;
            opnd        <= '0;
            op_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            zero_div    <= 1'b0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        cnt         <= '0;
                        div_by_zero <= 1'b0;
                        op_div      <= in_div;
                        neg_q       <= a_neg ^ b_neg;
                        neg_r       <= a_neg;
                        zero_div    <= in_div && b_zero;
                        if (in_div) begin
                            acc  <= {{WIDTH{1'b0}}, mag_a};
                            opnd <= b_zero ? a : mag_b;
                        end else begin
                            acc  <= {{WIDTH{1'b0}}, mag_b};
                            opnd <= mag_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (!flush) begin
                        acc <= step_acc | {{(2*WIDTH-1){1'b0}}, q_bit};
                        cnt <= cnt + 1'b1;
                    end
                end
                ST_FIX: begin
                    if (!flush) begin
                        done <= 1'b1;
                        if (zero_div) begin
                            hi          <= opnd;
                            lo          <= '1;
                            div_by_zero <= 1'b1;
                        end else if (op_div) begin
                            hi <= fix_hi;
                            lo <= fix_lo;
                        end else begin
                            {hi, lo} <= fix_prod;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
